md_ctrl: RTL and testbench

MD_CTRL -- requirements
Module: md_ctrl

---
 rtl/md_pkg.sv | 20 ++
 rtl/md_arith.sv | 58 +++++
 rtl/md_ctrl.sv | 107 ++++++++++
 tb/tb_md_ctrl.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/md_pkg.sv
// Shared encodings, latencies and state type
// for the HI/LO multiply/divide controller.
package md_pkg;

  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  localparam logic [3:0] MULT_CYC = 4'd5;
  localparam logic [3:0] DIV_CYC  = 4'd10;

  typedef enum logic {
    IDLE,
    BUSY
  } md_state_e;

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath
// producing the packed {hi,lo} result.
module md_arith
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] s_prod;
  logic [63:0] u_prod;
  logic [31:0] rs_mag;
  logic [31:0] rt_mag;
  logic [31:0] s_dvsr;
  logic [31:0] u_dvsr;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] s_quo;
  logic [31:0] s_rem;
  logic [31:0] u_quo;
  logic [31:0] u_rem;

  assign s_prod = $signed({{32{rs_val[31]}}, rs_val})
                * $signed({{32{rt_val[31]}}, rt_val});
  assign u_prod = {32'b0, rs_val} * {32'b0, rt_val};

  assign div_by_zero = (rt_val == 32'd0);

  // Signed divide on magnitudes; the zero-divisor
  // path is steered to 1 and its result discarded.
  assign rs_mag = rs_val[31] ? -rs_val : rs_val;
  assign rt_mag = rt_val[31] ? -rt_val : rt_val;
  assign s_dvsr = div_by_zero ? 32'd1 : rt_mag;
  assign u_dvsr = div_by_zero ? 32'd1 : rt_val;

  assign q_mag = rs_mag / s_dvsr;
  assign r_mag = rs_mag % s_dvsr;
  assign s_quo = (rs_val[31] ^ rt_val[31]) ? -q_mag : q_mag;
  assign s_rem = rs_val[31] ? -r_mag : r_mag;

  assign u_quo = rs_val / u_dvsr;
  assign u_rem = rs_val % u_dvsr;

  always_comb begin
    result = '0;
    unique case (op)
      MD_MULT:  result = s_prod;
      MD_MULTU: result = u_prod;
      MD_DIV:   result = {s_rem, s_quo};
      MD_DIVU:  result = {u_rem, u_quo};
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/md_ctrl.sv
// HI/LO sequencer: fixed-latency MULT/DIV
// with immediate MTHI/MTLO writes.
module md_ctrl
  import md_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_in_d,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_e   state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        dbz_q, dbz_d;
  logic [31:0] hi_d, lo_d;
  logic [63:0] arith_res;
  logic        arith_dbz;
  logic        is_mul, is_div, is_mthi, is_mtlo;

  md_arith u_arith (
    .op          (op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .result      (arith_res),
    .div_by_zero (arith_dbz)
  );

  assign is_mul  = (op == MD_MULT) || (op == MD_MULTU);
  assign is_div  = (op == MD_DIV) || (op == MD_DIVU);
  assign is_mthi = (op == MD_MTHI);
  assign is_mtlo = (op == MD_MTLO);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    dbz_d   = dbz_q;
    hi_d    = hi;
    lo_d    = lo;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          unique case (1'b1)
            is_mul: begin
              res_d   = arith_res;
              dbz_d   = 1'b0;
              cnt_d   = MULT_CYC;
              state_d = BUSY;
            end
            is_div: begin
              res_d   = arith_res;
              dbz_d   = arith_dbz;
              cnt_d   = DIV_CYC;
              state_d = BUSY;
            end
            is_mthi: hi_d = rs_val;
            is_mtlo: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      BUSY: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (!dbz_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= '0;
      dbz_q   <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      dbz_q   <= dbz_d;
      hi      <= hi_d;
      lo      <= lo_d;
    end
  end

  assign busy     = (state_q == BUSY);
  assign stall_md = md_in_d && (start || busy);

endmodule

// File: tb/tb_md_ctrl.sv
// Scoreboard bench for md_ctrl: driver pushes
// reference {hi,lo}, monitor pops on each write.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        md_in_d = 1'b0;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  exp_t q[$];
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  int n_chk = 0;
  int n_pass = 0;

  md_ctrl dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .op       (op),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_in_d  (md_in_d),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  function automatic void chk(string n, logic [31:0] act,
                              logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t",
                  n, act, exp, $time);
  endfunction

  // Reference arithmetic in 64-bit integers.
  function automatic exp_t ref_md(logic [2:0] o,
                                  logic [31:0] a,
                                  logic [31:0] b);
    exp_t e;
    longint          sp, sa, sb, sq, sr;
    longint unsigned up;
    e.hi = m_hi;
    e.lo = m_lo;
    case (o)
      3'd0: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        e.hi = sp[63:32];
        e.lo = sp[31:0];
      end
      3'd1: begin
        up = longint'(a) * longint'(b);
        e.hi = up[63:32];
        e.lo = up[31:0];
      end
      3'd2: if (b != 0) begin
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sq = sa / sb;
        sr = sa % sb;
        e.lo = sq[31:0];
        e.hi = sr[31:0];
      end
      3'd3: if (b != 0) begin
        e.lo = a / b;
        e.hi = a % b;
      end
      3'd4: e.hi = a;
      3'd5: e.lo = a;
      default: ;
    endcase
    return e;
  endfunction

  task automatic issue(input logic [2:0] o,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input bit ign);
    int   lat;
    exp_t e;
    start  = 1'b1;
    op     = o;
    rs_val = a;
    rt_val = b;
    lat = (o <= 3'd1) ? 5 : (o <= 3'd3) ? 10 : 0;
    if (o <= 3'd5) begin
      e = ref_md(o, a, b);
      q.push_back(e);
      m_hi = e.hi;
      m_lo = e.lo;
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < lat; k++) begin
      if (ign) begin
        start  = 1'($urandom_range(0, 1));
        op     = 3'($urandom_range(0, 7));
        rs_val = $urandom;
        rt_val = $urandom;
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 9));
      default: return $urandom;
    endcase
  endfunction

  // Monitor: spec-level busy window and write events.
  int          left = 0;
  bit          pend = 1'b0;
  logic [31:0] ah = '0;
  logic [31:0] al = '0;
  exp_t        me;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        left = 0;
        pend = 1'b0;
        q.delete();
        ah = '0;
        al = '0;
      end else if (left > 0) begin
        left--;
        if (left == 0) pend = 1'b1;
      end else if (start) begin
        if (op <= 3'd1) left = 5;
        else if (op <= 3'd3) left = 10;
        else if (op <= 3'd5) pend = 1'b1;
      end
      @(negedge clk);
      if (pend) begin
        pend = 1'b0;
        chk("sb_nonempty", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          me = q.pop_front();
          ah = me.hi;
          al = me.lo;
        end
      end
      chk("busy", 32'(busy), 32'(left > 0));
      chk("stall_md", 32'(stall_md),
          32'(md_in_d && (start || left > 0)));
      chk("hi", hi, ah);
      chk("lo", lo, al);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", hi, 32'd0);

    issue(3'd4, 32'h1234, 32'h0, 1'b0);
    issue(3'd5, 32'h5678, 32'h0, 1'b0);
    chk("mthi_val", hi, 32'h1234);

    md_in_d = 1'b1;
    issue(3'd0, 32'hFFFF_FFFD, 32'd7, 1'b0);
    md_in_d = 1'b0;
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    issue(3'd1, 32'hFFFF_FFFF, 32'd2, 1'b0);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    issue(3'd4, 32'h11, 32'h0, 1'b0);
    issue(3'd5, 32'h22, 32'h0, 1'b0);
    issue(3'd3, 32'h1234_5678, 32'h0, 1'b0);
    chk("divu0_hi", hi, 32'h11);
    chk("divu0_lo", lo, 32'h22);

    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    issue(3'd6, 32'h1, 32'h2, 1'b0);
    issue(3'd7, 32'h1, 32'h2, 1'b0);

    start  = 1'b1;
    op     = 3'd2;
    rs_val = 32'd1000;
    rt_val = 32'd7;
    q.push_back(ref_md(3'd2, 32'd1000, 32'd7));
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    m_hi = '0;
    m_lo = '0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_hi", hi, 32'd0);
    chk("abort_lo", lo, 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk("late_hi", hi, 32'd0);

    for (int i = 0; i < 40; i++) begin
      md_in_d = 1'($urandom_range(0, 1));
      issue(3'($urandom_range(0, 7)), pick(), pick(), 1'b1);
    end
    md_in_d = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
